// File: rtl/apb_lsu.sv
// apb_lsu: RISC-V load/store unit that turns one request into one APB transfer.
// Covers size/alignment checks, byte strobes, store replication, load extension and an ACCESS timeout.
module apb_lsu #(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AW-1:0]     paddr,
    output logic [XLEN-1:0]   pwdata,
    output logic [XLEN/8-1:0] pstrb,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [XLEN-1:0]   prdata
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = (XLEN == 64) ? 3 : 2;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_SLV     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   addr_reg;
    logic [2:0]      funct3_reg;
    logic            write_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [15:0]     wait_cnt_reg, wait_cnt_next;
    logic [1:0]      err_reg, err_next;
    logic [XLEN-1:0] rdata_reg, rdata_next;

    logic            handshake;
    logic            req_legal;
    logic            req_misaligned;
    logic [NB-1:0]   size_mask;
    logic [NB-1:0]   strb;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] extended;
    logic            sign_bit;
    int              size_bits;

    assign handshake = req_valid && (state_reg == IDLE);

    // Legality and alignment are judged on the raw request so the FSM can branch at the handshake.
    always_comb begin
        req_legal = 1'b1;
        if (req_write && req_funct3[2]) begin
            req_legal = 1'b0;
        end
        case (req_funct3)
            3'b011, 3'b110: begin
                if (XLEN != 64) begin
                    req_legal = 1'b0;
                end
            end
            3'b111:  req_legal = 1'b0;
            default: ;
        endcase
        case (req_funct3[1:0])
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            default: req_misaligned = |req_addr[2:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_reg   <= '0;
            funct3_reg <= '0;
            write_reg  <= 1'b0;
            wdata_reg  <= '0;
        end else if (handshake) begin
            addr_reg   <= req_addr;
            funct3_reg <= req_funct3;
            write_reg  <= req_write;
            wdata_reg  <= req_wdata;
        end
    end

    always_comb begin
        case (funct3_reg[1:0])
            2'b00:   size_mask = NB'(1);
            2'b01:   size_mask = NB'(3);
            2'b10:   size_mask = NB'(15);
            default: size_mask = '1;
        endcase
    end

    assign strb = size_mask << addr_reg[OFFW-1:0];

    // Each byte lane picks the store byte at its position modulo the access size.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign pwdata[8*gi +: 8] =
            (funct3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
            (funct3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi % 2) +: 8] :
            (funct3_reg[1:0] == 2'b10) ? wdata_reg[8*(gi % 4) +: 8] :
                                         wdata_reg[8*gi +: 8];
    end

    always_comb begin
        shifted = prdata >> {addr_reg[OFFW-1:0], 3'b000};
        case (funct3_reg[1:0])
            2'b00: begin
                size_bits = 8;
                sign_bit  = shifted[7];
            end
            2'b01: begin
                size_bits = 16;
                sign_bit  = shifted[15];
            end
            2'b10: begin
                size_bits = 32;
                sign_bit  = shifted[31];
            end
            default: begin
                size_bits = XLEN;
                sign_bit  = shifted[XLEN-1];
            end
        endcase
        extended = shifted;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= size_bits) begin
                extended[i] = sign_bit & ~funct3_reg[2];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        err_next      = err_reg;
        rdata_next    = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    rdata_next = '0;
                    if (req_legal && !req_misaligned) begin
                        state_next = SETUP;
                        err_next   = ERR_OK;
                    end else begin
                        state_next = RESP;
                        err_next   = ERR_ALIGN;
                    end
                end
            end
            SETUP: begin
                state_next    = ACCESS;
                wait_cnt_next = '0;
            end
            ACCESS: begin
                if (pready) begin
                    state_next = RESP;
                    err_next   = pslverr ? ERR_SLV : ERR_OK;
                    rdata_next = (write_reg || pslverr) ? '0 : extended;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_next = RESP;
                        err_next   = ERR_TIMEOUT;
                        rdata_next = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            err_reg      <= ERR_OK;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
            rdata_reg    <= rdata_next;
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign psel      = (state_reg == SETUP) || (state_reg == ACCESS);
    assign penable   = (state_reg == ACCESS);
    assign pwrite    = write_reg;
    assign paddr     = {addr_reg[AW-1:OFFW], {OFFW{1'b0}}};
    assign pstrb     = (psel && write_reg) ? strb : '0;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = rsp_valid ? err_reg : ERR_OK;
    assign rsp_rdata = rsp_valid ? rdata_reg : '0;

endmodule
